pe_scheduler: RTL and testbench
===============================

# pe_scheduler

Shares one PE dot-product unit (C-element MAC with enable-low clear, v_valid completion pulse) among N_REQ requesters. Round-robin arbitration, latches the winner's x/k vectors, drives the PE enable window, captures the truncated result, and returns it with the requester ID over a valid/ready response channel. Sits between the vector-issue front end and the PE instance.

## Interface
- N_REQ, 4: number of requesters (≥2)
- C, 16: vector length; must match the PE
- W_X, 32: x element width and result width
- W_K, 32: k element width
- TIMEOUT, C+4: max RUN cycles waiting for pe_v_valid before error
- W_ID, $clog2(N_REQ): requester ID width (derived)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  [N_REQ]  requester i has an operation
- req_ready  out  [N_REQ]  one-hot grant/accept; handshake = valid & ready
- req_x  in  [N_REQ][C][W_X]  signed x vectors
- req_k  in  [N_REQ][C][W_K]  signed k vectors
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  W_ID  requester that issued the result
- rsp_y  out  W_X  signed truncated dot product
- rsp_err  out  1  PE timed out; rsp_y forced 0
- pe_enable  out  1  to PE enable; low = PE cleared
- pe_x  out  [C][W_X]  latched x to PE
- pe_k  out  [C][W_K]  latched k to PE
- pe_y  in  W_X  PE y_out
- pe_v_valid  in  1  PE completion pulse
- busy  out  1  state != IDLE

## Operation
- FSM: IDLE, RUN, RESP.
- IDLE: pe_enable=0. If any req_valid, round-robin grant g (search starts at last_grant+1, modulo N_REQ); req_ready[g]=1 combinationally, all other bits 0. On handshake: latch req_x[g]/req_k[g] into pe_x/pe_k, id<=g, last_grant<=g, pe_enable<=1, cnt<=0, go RUN.
- req_ready is 0 in RUN and RESP; requesters hold req_valid and data until accepted.
- RUN: pe_enable=1, cnt increments each cycle. pe_v_valid=1: rsp_y<=pe_y, rsp_err<=0, pe_enable<=0, go RESP. Else cnt==TIMEOUT-1: rsp_y<=0, rsp_err<=1, pe_enable<=0, go RESP.
- RESP: rsp_valid=1, rsp_id/rsp_y/rsp_err stable until rsp_valid & rsp_ready; then go IDLE. pe_enable stays 0, so the PE is cleared before the next operation.
- pe_v_valid outside RUN is ignored.
- No arithmetic in this block. rsp_y is pe_y passed through unchanged: low W_X bits of the full-precision sum.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, pe_enable=0, rsp_valid=0, rsp_err=0, rsp_y=0, rsp_id=0, pe_x=pe_k=0, cnt=0, last_grant=N_REQ-1 (first grant goes to requester 0). busy=0 and req_ready=0 while rst_n=0.
- Reset mid-operation aborts. The latched request is dropped with no response, and pe_enable is 0 the cycle after.
- Accept at edge T: pe_enable high from T. The PE asserts v_valid after edge T+C+1. The block samples it at edge T+C+2, so rsp_valid is high after edge T+C+2 (latency C+2).
- pe_enable is never high for more than TIMEOUT cycles. This stops a PE counter wrap from producing a second v_valid.
- Back-to-back throughput: RESP handshake at edge R means the earliest next accept is at edge R+1.
- A requester whose req_valid drops before being granted is simply skipped; no state is kept.

## Structure
- Shared package pe_pkg holds:
  - the state enum (IDLE, RUN, RESP);
  - the default C/W_X/W_K values;
  - a helper for the TIMEOUT default.
- Sub-module rr_arbiter #(N) (req, last_grant, grant_onehot, grant_idx), purely combinational. It is reusable by other shared-resource schedulers.
- The bench instantiates pe_scheduler with a real PE instance.

## Test plan
- Single request, C=16: x[i]=i+1, k[i]=2, requester 1 → rsp_valid exactly C+2 cycles after accept, rsp_y=272, rsp_id=1, rsp_err=0.
- All 4 req_valid held high, rsp_ready=1 → grants in order 0,1,2,3,0. Each response carries the matching ID and result.
- rsp_ready held low 10 cycles → rsp_valid, rsp_id and rsp_y stable. req_ready stays 0 throughout, and pe_enable=0.
- Signed/truncation: x[i]=-1, k[i]=0x7FFFFFFF for all i → rsp_y = low 32 bits of -16·(2^31-1) = 0x00000010.
- PE model that never asserts v_valid → rsp_err=1 and rsp_y=0 after TIMEOUT RUN cycles. pe_enable is low in RESP.
- rst_n pulsed low during RUN → no response, all outputs at reset values, next request starts at requester 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the PE scheduler: FSM encoding, default PE geometry
// and the default RUN-phase timeout.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int C_DEF   = 16;
    localparam int W_X_DEF = 32;
    localparam int W_K_DEF = 32;

    // A few cycles of slack beyond the PE's nominal C+2 latency.
    function automatic int timeout_default(input int c);
        return c + 4;
    endfunction

endpackage

// File: rtl/pe_dot.sv
// Serial C-element signed MAC. Low enable clears it; one element is consumed
// per enabled cycle and v_valid pulses once, the cycle after the last element.
module pe_dot #(
    parameter int C   = 16,
    parameter int W_X = 32,
    parameter int W_K = 32
) (
    input  logic                    clk,
    input  logic                    enable,
    input  logic [C-1:0][W_X-1:0]   x,
    input  logic [C-1:0][W_K-1:0]   k,
    output logic [W_X-1:0]          y_out,
    output logic                    v_valid
);

    localparam int IW = $clog2(C);
    localparam int CW = $clog2(C + 2);
    localparam int AW = W_X + W_K + IW;

    logic        [CW-1:0]      idx_q;
    logic signed [AW-1:0]      acc_q;
    logic                      v_q;
    logic signed [W_X+W_K-1:0] prod;
    logic                      unused_acc_hi;

    assign prod = $signed(x[idx_q[IW-1:0]]) * $signed(k[idx_q[IW-1:0]]);

    // idx saturates at C+1 so a long enable window never re-fires v_valid.
    always_ff @(posedge clk) begin
        if (!enable) begin
            idx_q <= '0;
            acc_q <= '0;
            v_q   <= 1'b0;
        end else begin
            v_q <= 1'b0;
            if (idx_q < CW'(C)) begin
                acc_q <= acc_q + AW'(prod);
                idx_q <= idx_q + 1'b1;
            end else if (idx_q == CW'(C)) begin
                v_q   <= 1'b1;
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign y_out         = acc_q[W_X-1:0];
    assign v_valid       = v_q;
    assign unused_acc_hi = ^acc_q[AW-1:W_X];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// grant and wraps modulo N, so every requester is served in turn.
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [N-1:0] grant_onehot,
    output logic [W-1:0] grant_idx
);

    int   j;
    logic found;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        j            = 0;
        for (int i = 1; i <= N; i++) begin
            j = (int'(last_grant) + i) % N;
            if (!found && req[j]) begin
                found           = 1'b1;
                grant_onehot[j] = 1'b1;
                grant_idx       = j[W-1:0];
            end
        end
    end

endmodule

// File: rtl/pe_scheduler.sv
// Time-shares one PE dot-product unit among N_REQ requesters: round-robin
// grant, operand latch, PE enable window with timeout, buffered response.
module pe_scheduler
    import pe_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int C       = C_DEF,
    parameter int W_X     = W_X_DEF,
    parameter int W_K     = W_K_DEF,
    parameter int TIMEOUT = timeout_default(C),
    parameter int W_ID    = $clog2(N_REQ)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    // Handshakes on both channels: a transfer happens on a rising edge where
    // valid and ready are both high; the source holds valid and data until then.
    input  logic [N_REQ-1:0]                   req_valid,
    output logic [N_REQ-1:0]                   req_ready,
    input  logic [N_REQ-1:0][C-1:0][W_X-1:0]   req_x,
    input  logic [N_REQ-1:0][C-1:0][W_K-1:0]   req_k,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [W_ID-1:0]                    rsp_id,
    output logic [W_X-1:0]                     rsp_y,
    output logic                               rsp_err,
    output logic                               pe_enable,
    output logic [C-1:0][W_X-1:0]              pe_x,
    output logic [C-1:0][W_K-1:0]              pe_k,
    input  logic [W_X-1:0]                     pe_y,
    input  logic                               pe_v_valid,
    output logic                               busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e                    state_q, state_d;
    logic [N_REQ-1:0]          grant_onehot;
    logic [W_ID-1:0]           grant_idx;
    logic [W_ID-1:0]           last_grant_q, id_q;
    logic [CW-1:0]             cnt_q;
    logic                      pe_enable_q, rsp_err_q;
    logic [W_X-1:0]            rsp_y_q;
    logic [C-1:0][W_X-1:0]     pe_x_q;
    logic [C-1:0][W_K-1:0]     pe_k_q;
    logic                      accept, done, expire;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req          (req_valid),
        .last_grant   (last_grant_q),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    assign accept = (state_q == IDLE) && (|req_valid);
    assign done   = (state_q == RUN) && pe_v_valid;
    assign expire = (state_q == RUN) && !pe_v_valid && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)          state_d = RUN;
            RUN:     if (done || expire)  state_d = RESP;
            RESP:    if (rsp_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        if (rst_n) begin
            req_ready = (state_q == IDLE) ? grant_onehot : '0;
            rsp_valid = (state_q == RESP);
            busy      = (state_q != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pe_x_q       <= '0;
            pe_k_q       <= '0;
            id_q         <= '0;
            last_grant_q <= W_ID'(N_REQ - 1);
            pe_enable_q  <= 1'b0;
            cnt_q        <= '0;
            rsp_y_q      <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                pe_x_q       <= req_x[grant_idx];
                pe_k_q       <= req_k[grant_idx];
                id_q         <= grant_idx;
                last_grant_q <= grant_idx;
                pe_enable_q  <= 1'b1;
                cnt_q        <= '0;
            end
            // Dropping enable on exit also clears the PE before the next job.
            if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
                if (done) begin
                    rsp_y_q     <= pe_y;
                    rsp_err_q   <= 1'b0;
                    pe_enable_q <= 1'b0;
                end else if (expire) begin
                    rsp_y_q     <= '0;
                    rsp_err_q   <= 1'b1;
                    pe_enable_q <= 1'b0;
                end
            end
        end
    end

    assign pe_enable = pe_enable_q;
    assign pe_x      = pe_x_q;
    assign pe_k      = pe_k_q;
    assign rsp_id    = id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_pe_scheduler.sv
// Bench for pe_scheduler driving a real pe_dot; responses are checked by a
// scoreboard monitor against hand-computed expected values.
module tb_pe_scheduler;

    localparam int N    = 4;
    localparam int C    = 16;
    localparam int W_X  = 32;
    localparam int W_K  = 32;
    localparam int TO   = C + 4;
    localparam int W_ID = 2;

    logic                         clk;
    logic                         rst_n;
    logic [N-1:0]                 req_valid;
    logic [N-1:0]                 req_ready;
    logic [N-1:0][C-1:0][W_X-1:0] req_x;
    logic [N-1:0][C-1:0][W_K-1:0] req_k;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [W_ID-1:0]              rsp_id;
    logic [W_X-1:0]               rsp_y;
    logic                         rsp_err;
    logic                         pe_enable;
    logic [C-1:0][W_X-1:0]        pe_x;
    logic [C-1:0][W_K-1:0]        pe_k;
    logic [W_X-1:0]               pe_y;
    logic                         pe_vv;
    logic                         pe_mute;
    logic                         pe_v_valid;
    logic                         busy;

    logic [W_ID-1:0] exp_id_q[$];
    logic [W_X-1:0]  exp_y_q[$];
    logic [0:0]      exp_err_q[$];

    int checks;
    int errors;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pe_v_valid = pe_vv & ~pe_mute;

    pe_scheduler #(.N_REQ(N), .C(C), .W_X(W_X), .W_K(W_K), .TIMEOUT(TO), .W_ID(W_ID)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_k      (req_k),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_err    (rsp_err),
        .pe_enable  (pe_enable),
        .pe_x       (pe_x),
        .pe_k       (pe_k),
        .pe_y       (pe_y),
        .pe_v_valid (pe_v_valid),
        .busy       (busy)
    );

    pe_dot #(.C(C), .W_X(W_X), .W_K(W_K)) u_pe (
        .clk     (clk),
        .enable  (pe_enable),
        .x       (pe_x),
        .k       (pe_k),
        .y_out   (pe_y),
        .v_valid (pe_vv)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_id_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id %0d y 0x%0h, none expected", rsp_id, rsp_y);
                end else begin
                    check("rsp_id",  rsp_id,  exp_id_q.pop_front());
                    check("rsp_y",   rsp_y,   exp_y_q.pop_front());
                    check("rsp_err", rsp_err, exp_err_q.pop_front());
                end
            end
        end
    endtask

    // drivers
    task automatic expect_rsp(input int id, input logic [W_X-1:0] y, input logic err);
        exp_id_q.push_back(W_ID'(id));
        exp_y_q.push_back(y);
        exp_err_q.push_back(err);
    endtask

    // mode 0: x=r+1,k=i   mode 1: x=i+1,k=2   mode 2: x=-1,k=0x7FFFFFFF
    task automatic set_req(input int r, input int mode);
        for (int i = 0; i < C; i++) begin
            case (mode)
                0: begin req_x[r][i] = W_X'(r + 1); req_k[r][i] = W_K'(i);     end
                1: begin req_x[r][i] = W_X'(i + 1); req_k[r][i] = W_K'(2);     end
                default: begin req_x[r][i] = 32'hFFFF_FFFF; req_k[r][i] = 32'h7FFF_FFFF; end
            endcase
        end
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                check("grant_onehot", 64'($countones(req_ready)), 64'd1);
                for (int i = 0; i < N; i++)
                    if (req_valid[i] && req_ready[i]) g = i;
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL grant_timeout: got no grant, req_valid=%b", req_valid);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            lat++;
            #1;
            if (rsp_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles", lat);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      busy,       0);
        check({tag, "_rsp_valid"}, rsp_valid,  0);
        check({tag, "_pe_enable"}, pe_enable,  0);
        check({tag, "_rsp_y"},     rsp_y,      0);
        check({tag, "_rsp_err"},   rsp_err,    0);
        check({tag, "_rsp_id"},    rsp_id,     0);
        check({tag, "_pe_x"},      {63'd0, |pe_x}, 0);
        check({tag, "_pe_k"},      {63'd0, |pe_k}, 0);
        check({tag, "_req_ready"}, req_ready,  0);
    endtask

    int g;
    int lat;
    int ops_left[N];
    int exp_order[5];

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_k     = '0;
        rsp_ready = 1'b1;
        pe_mute   = 1'b0;
        fork
            monitor();
        join_none

        // reset values, with requests pending to show req_ready is held low
        repeat (3) @(posedge clk);
        #1;
        req_valid = 4'b0101;
        #1;
        check_idle_outputs("reset");
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;

        // all requesters held valid: grants 0,1,2,3,0
        for (int r = 0; r < N; r++) set_req(r, 0);
        expect_rsp(0, 32'd120, 1'b0);
        expect_rsp(1, 32'd240, 1'b0);
        expect_rsp(2, 32'd360, 1'b0);
        expect_rsp(3, 32'd480, 1'b0);
        expect_rsp(0, 32'd120, 1'b0);
        exp_order = '{0, 1, 2, 3, 0};
        ops_left  = '{2, 1, 1, 1};
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            wait_grant(g);
            check("grant_order", g, exp_order[n]);
            if (g >= 0) begin
                ops_left[g]--;
                if (ops_left[g] == 0) req_valid[g] = 1'b0;
            end
            wait_rsp(lat);
            check("rr_latency", lat, C + 2);
            @(posedge clk);
            #1;
        end

        // single request from requester 1: y = 2*sum(1..16) = 272
        set_req(1, 1);
        expect_rsp(1, 32'd272, 1'b0);
        req_valid[1] = 1'b1;
        wait_grant(g);
        req_valid[1] = 1'b0;
        check("single_grant", g, 1);
        check("single_no_early_rsp", rsp_valid, 0);
        check("single_pe_enable", pe_enable, 1);
        check("single_busy", busy, 1);
        wait_rsp(lat);
        check("single_latency", lat, C + 2);
        @(posedge clk);
        #1;
        check("single_idle_busy", busy, 0);
        check("single_idle_pe_enable", pe_enable, 0);

        // response stall for 10 cycles with another requester waiting
        set_req(2, 0);
        set_req(3, 0);
        expect_rsp(2, 32'd360, 1'b0);
        expect_rsp(3, 32'd480, 1'b0);
        rsp_ready    = 1'b0;
        req_valid[2] = 1'b1;
        wait_grant(g);
        check("stall_grant", g, 2);
        req_valid[2] = 1'b0;
        req_valid[3] = 1'b1;
        wait_rsp(lat);
        for (int n = 0; n < 10; n++) begin
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_id",    rsp_id,    2);
            check("stall_rsp_y",     rsp_y,     360);
            check("stall_req_ready", req_ready, 0);
            check("stall_pe_enable", pe_enable, 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        wait_grant(g);
        check("after_stall_grant", g, 3);
        req_valid[3] = 1'b0;
        wait_rsp(lat);
        @(posedge clk);
        #1;

        // signed product with truncation: low 32 bits of -16*(2^31-1)
        set_req(0, 2);
        expect_rsp(0, 32'h0000_0010, 1'b0);
        req_valid[0] = 1'b1;
        wait_grant(g);
        req_valid[0] = 1'b0;
        wait_rsp(lat);
        @(posedge clk);
        #1;

        // PE never completes: timeout after TO RUN cycles
        pe_mute   = 1'b1;
        rsp_ready = 1'b0;
        set_req(1, 1);
        expect_rsp(1, 32'd0, 1'b1);
        req_valid[1] = 1'b1;
        wait_grant(g);
        check("timeout_grant", g, 1);
        req_valid[1] = 1'b0;
        wait_rsp(lat);
        check("timeout_latency", lat, TO);
        check("timeout_err", rsp_err, 1);
        check("timeout_y", rsp_y, 0);
        check("timeout_pe_enable", pe_enable, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        pe_mute = 1'b0;

        // reset during RUN: no response, restart from requester 0
        set_req(2, 0);
        req_valid[2] = 1'b1;
        wait_grant(g);
        req_valid[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        set_req(0, 0);
        set_req(3, 0);
        req_valid = 4'b1001;
        @(posedge clk);
        #1;
        check_idle_outputs("midrst");
        rst_n = 1'b1;
        expect_rsp(0, 32'd120, 1'b0);
        expect_rsp(3, 32'd480, 1'b0);
        wait_grant(g);
        check("post_reset_grant", g, 0);
        req_valid[0] = 1'b0;
        wait_rsp(lat);
        @(posedge clk);
        #1;
        wait_grant(g);
        check("post_reset_second_grant", g, 3);
        req_valid[3] = 1'b0;
        wait_rsp(lat);
        @(posedge clk);
        #1;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_id_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
